// File: rtl/dram_byte_bridge.sv
// Serialises 32-bit MEM-stage requests into byte accesses on an 8-bit async SRAM.
// Read: 1 + 4*(RD_WAIT+1) stall cycles; write: 1 + (WR_PULSE+1) per selected lane. Holds the pipeline via stallreq_o.
module dram_byte_bridge #(
  parameter int ADDR_W   = 17,
  parameter int RD_WAIT  = 1,
  parameter int WR_PULSE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [31:0]       mem_data_i,
  output logic [31:0]       mem_data_o,
  output logic              stallreq_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_data_o,
  input  logic [7:0]        ram_data_i,
  output logic              ram_ce_o,
  output logic              ram_oe_o,
  output logic              ram_we_o
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [7:0] RD_LAST = 8'(RD_WAIT);
  localparam logic [7:0] WR_LAST = 8'(WR_PULSE - 1);
  localparam logic [7:0] WR_HOLD = 8'(WR_PULSE);

  state_t            state;
  logic [ADDR_W-3:0] base_q;
  logic [3:0]        sel_q;
  logic [31:0]       data_q;
  logic [31:0]       word_q;
  logic [31:0]       word_nxt;
  logic [1:0]        idx;
  logic [7:0]        cnt;
  logic [2:0]        first_sel;
  logic [2:0]        next_sel;
  logic              unused_addr_bits;

  // Lowest set lane at or above 'from'; 3'd4 means no lane left.
  function automatic logic [2:0] next_lane(input logic [3:0] sel, input logic [2:0] from);
    logic [2:0] res;
    res = 3'd4;
    for (int k = 3; k >= 0; k--) begin
      if (sel[k] && 3'(k) >= from) res = 3'(k);
    end
    return res;
  endfunction

  assign first_sel        = next_lane(mem_sel_i, 3'd0);
  assign next_sel         = next_lane(sel_q, {1'b0, idx} + 3'd1);
  assign stallreq_o       = (state == IDLE && mem_ce_i) || state == RD || state == WR;
  assign unused_addr_bits = ^{mem_addr_i[31:ADDR_W], mem_addr_i[1:0]};

  always_comb begin
    word_nxt = word_q;
    word_nxt[8*idx +: 8] = ram_data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      base_q     <= '0;
      sel_q      <= '0;
      data_q     <= '0;
      word_q     <= '0;
      idx        <= '0;
      cnt        <= '0;
      mem_data_o <= '0;
      ram_addr_o <= '0;
      ram_data_o <= '0;
      ram_ce_o   <= 1'b0;
      ram_oe_o   <= 1'b0;
      ram_we_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_ce_i) begin
            base_q <= mem_addr_i[ADDR_W-1:2];
            sel_q  <= mem_sel_i;
            data_q <= mem_data_i;
            cnt    <= '0;
            if (!mem_we_i) begin
              state      <= RD;
              idx        <= 2'd0;
              ram_ce_o   <= 1'b1;
              ram_oe_o   <= 1'b1;
              ram_addr_o <= {mem_addr_i[ADDR_W-1:2], 2'd0};
            end else if (first_sel[2]) begin
              state <= DONE;
            end else begin
              state      <= WR;
              idx        <= first_sel[1:0];
              ram_ce_o   <= 1'b1;
              ram_we_o   <= 1'b1;
              ram_addr_o <= {mem_addr_i[ADDR_W-1:2], first_sel[1:0]};
              ram_data_o <= mem_data_i[8*first_sel[1:0] +: 8];
            end
          end
        end
        RD: begin
          if (cnt != RD_LAST) begin
            cnt <= cnt + 8'd1;
          end else begin
            cnt    <= '0;
            word_q <= word_nxt;
            if (idx == 2'd3) begin
              state      <= DONE;
              mem_data_o <= word_nxt;
              ram_ce_o   <= 1'b0;
              ram_oe_o   <= 1'b0;
            end else begin
              idx        <= idx + 2'd1;
              ram_addr_o <= {base_q, idx + 2'd1};
            end
          end
        end
        WR: begin
          // Strobe for WR_PULSE cycles, then one cycle with addr/data held for hold time.
          if (cnt == WR_HOLD) begin
            cnt <= '0;
            if (next_sel[2]) begin
              state    <= DONE;
              ram_ce_o <= 1'b0;
            end else begin
              idx        <= next_sel[1:0];
              ram_we_o   <= 1'b1;
              ram_addr_o <= {base_q, next_sel[1:0]};
              ram_data_o <= data_q[8*next_sel[1:0] +: 8];
            end
          end else begin
            if (cnt == WR_LAST) ram_we_o <= 1'b0;
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_byte_bridge.sv
// Scoreboard bench for dram_byte_bridge: default instance plus an RD_WAIT=3 instance.
module tb_dram_byte_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_ce, a_we, a_stall, a_rce, a_roe, a_rwe;
  logic [31:0] a_addr, a_wd, a_rd;
  logic [3:0]  a_sel;
  logic [16:0] a_raddr;
  logic [7:0]  a_rwd, a_rrd;

  logic        b_ce, b_we, b_stall, b_rce, b_roe, b_rwe;
  logic [31:0] b_addr, b_wd, b_rd;
  logic [3:0]  b_sel;
  logic [16:0] b_raddr;
  logic [7:0]  b_rwd, b_rrd;

  dram_byte_bridge dut_a (
    .clk(clk), .rst(rst), .mem_ce_i(a_ce), .mem_we_i(a_we), .mem_addr_i(a_addr),
    .mem_sel_i(a_sel), .mem_data_i(a_wd), .mem_data_o(a_rd), .stallreq_o(a_stall),
    .ram_addr_o(a_raddr), .ram_data_o(a_rwd), .ram_data_i(a_rrd),
    .ram_ce_o(a_rce), .ram_oe_o(a_roe), .ram_we_o(a_rwe)
  );

  dram_byte_bridge #(.ADDR_W(17), .RD_WAIT(3), .WR_PULSE(1)) dut_b (
    .clk(clk), .rst(rst), .mem_ce_i(b_ce), .mem_we_i(b_we), .mem_addr_i(b_addr),
    .mem_sel_i(b_sel), .mem_data_i(b_wd), .mem_data_o(b_rd), .stallreq_o(b_stall),
    .ram_addr_o(b_raddr), .ram_data_o(b_rwd), .ram_data_i(b_rrd),
    .ram_ce_o(b_rce), .ram_oe_o(b_roe), .ram_we_o(b_rwe)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // SRAM models (byte arrays, low 8 address bits)
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  assign a_rrd = (a_rce && a_roe) ? mem_a[a_raddr[7:0]] : 8'h00;
  assign b_rrd = (b_rce && b_roe) ? mem_b[b_raddr[7:0]] : 8'h00;
  always @(posedge clk) if (a_rce && a_rwe) mem_a[a_raddr[7:0]] = a_rwd;
  always @(posedge clk) if (b_rce && b_rwe) mem_b[b_raddr[7:0]] = b_rwd;

  // Expected responses and SRAM activity
  bit          ea_rd[$];
  logic [31:0] ea_data[$];
  int          ea_stall[$];
  string       ea_name[$];
  logic [31:0] eb_data[$];
  int          eb_stall[$];
  logic [16:0] wq_addr[$];
  logic [7:0]  wq_dat[$];
  logic [16:0] bq_addr[$];

  // Response monitor, instance A
  int a_cnt = 0;
  always @(negedge clk) begin
    if (!rst) a_cnt = 0;
    else if (a_ce && a_stall) a_cnt++;
    else if (a_ce) begin
      if (ea_name.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL a_unexpected_resp: got completion, required none");
      end else begin
        string nm;
        bit    rd;
        logic [31:0] d;
        nm = ea_name.pop_front();
        rd = ea_rd.pop_front();
        d  = ea_data.pop_front();
        check({nm, "_stall"}, a_cnt, ea_stall.pop_front());
        if (rd) check({nm, "_rdata"}, a_rd, d);
      end
      a_cnt = 0;
    end
  end

  // SRAM bus monitor, instance A
  always @(negedge clk) begin
    if (rst) begin
      if (a_roe && a_rwe) begin
        n_cmp++; n_bad++;
        $display("FAIL a_oe_we_overlap: got both 1, required exclusive");
      end
      if (a_rwe) begin
        if (wq_addr.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL a_unexpected_write: got addr 0x%0h data 0x%0h, required none", a_raddr, a_rwd);
        end else begin
          check("a_wr_addr", a_raddr, wq_addr.pop_front());
          check("a_wr_data", a_rwd, wq_dat.pop_front());
        end
      end
    end
  end

  // Monitors, instance B
  int b_cnt = 0;
  always @(negedge clk) begin
    if (!rst) b_cnt = 0;
    else begin
      if (b_roe) begin
        if (bq_addr.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b_extra_read_cycle: got addr 0x%0h, required none", b_raddr);
        end else check("b_rd_addr", b_raddr, bq_addr.pop_front());
      end
      if (b_rwe) begin
        n_cmp++; n_bad++;
        $display("FAIL b_write_pulse: got ram_we_o=1, required 0");
      end
      if (b_ce && b_stall) b_cnt++;
      else if (b_ce) begin
        if (eb_data.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b_unexpected_resp: got completion, required none");
        end else begin
          check("b_stall", b_cnt, eb_stall.pop_front());
          check("b_rdata", b_rd, eb_data.pop_front());
        end
        b_cnt = 0;
      end
    end
  end

  task automatic issue(input string nm, input bit we, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] data, input logic [31:0] exp_rd, input int exp_stall);
    int k;
    ea_name.push_back(nm);
    ea_rd.push_back(!we);
    ea_data.push_back(exp_rd);
    ea_stall.push_back(exp_stall);
    @(posedge clk); #1;
    a_ce = 1'b1; a_we = we; a_addr = addr; a_sel = sel; a_wd = data;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!a_stall) break;
    end
    if (k == 100) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got stall after 100 cycles, required release", nm);
    end
    @(posedge clk); #1;
    a_ce = 1'b0; a_we = 1'b0; a_addr = '0; a_sel = '0; a_wd = '0;
  endtask

  task automatic check_a_idle(input string nm);
    check({nm, "_rdata"}, a_rd, 32'h0);
    check({nm, "_stall"}, a_stall, 32'h0);
    check({nm, "_raddr"}, a_raddr, 32'h0);
    check({nm, "_rwdata"}, a_rwd, 32'h0);
    check({nm, "_ce"}, a_rce, 32'h0);
    check({nm, "_oe"}, a_roe, 32'h0);
    check({nm, "_we"}, a_rwe, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    bit found;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'hEE;
      mem_b[i] = 8'h00;
    end
    mem_b[16] = 8'h5A; mem_b[17] = 8'h6B; mem_b[18] = 8'h7C; mem_b[19] = 8'h8D;
    a_ce = 0; a_we = 0; a_addr = 0; a_sel = 0; a_wd = 0;
    b_ce = 0; b_we = 0; b_addr = 0; b_sel = 0; b_wd = 0;
    rst = 1'b1;
    #3 rst = 1'b0;
    #1 check_a_idle("reset");
    check("reset_b_rdata", b_rd, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Full word write
    wq_addr.push_back(17'h10); wq_dat.push_back(8'h44);
    wq_addr.push_back(17'h11); wq_dat.push_back(8'h33);
    wq_addr.push_back(17'h12); wq_dat.push_back(8'h22);
    wq_addr.push_back(17'h13); wq_dat.push_back(8'h11);
    issue("sw", 1'b1, 32'h10, 4'b1111, 32'h11223344, 32'h0, 9);

    // Single lane write
    wq_addr.push_back(17'h22); wq_dat.push_back(8'hAA);
    issue("sb", 1'b1, 32'h22, 4'b0100, 32'hAAAAAAAA, 32'h0, 3);

    issue("lw10", 1'b0, 32'h10, 4'b1111, 32'h0, 32'h11223344, 9);
    // sel is ignored on reads: all four bytes come back
    issue("lw20", 1'b0, 32'h20, 4'b0001, 32'h0, 32'hEEAAEEEE, 9);

    // Empty-lane write: no SRAM cycle, read data untouched
    issue("sw_nosel", 1'b1, 32'h30, 4'b0000, 32'hDEADBEEF, 32'h0, 1);
    check("rdata_kept_after_write", a_rd, 32'hEEAAEEEE);

    // Reset in the middle of a read at byte 2
    @(posedge clk); #1;
    a_ce = 1'b1; a_we = 1'b0; a_addr = 32'h10; a_sel = 4'hF;
    found = 1'b0;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (a_roe && a_raddr[1:0] == 2'd2) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reached_idx2", found, 32'h1);
    #2;
    a_ce = 1'b0;
    rst  = 1'b0;
    #1 check_a_idle("abort");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    issue("lw_after_abort", 1'b0, 32'h10, 4'b1111, 32'h0, 32'h11223344, 9);

    // RD_WAIT=3 instance with aliased upper address bits
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) bq_addr.push_back(17'h10 + 17'(i));
    eb_data.push_back(32'h8D7C6B5A);
    eb_stall.push_back(17);
    @(posedge clk); #1;
    b_ce = 1'b1; b_we = 1'b0; b_addr = 32'h00020010; b_sel = 4'hF;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!b_stall) break;
    end
    if (k == 100) begin
      n_cmp++; n_bad++;
      $display("FAIL b_timeout: got stall after 100 cycles, required release");
    end
    @(posedge clk); #1;
    b_ce = 1'b0; b_addr = '0; b_sel = '0;
    repeat (3) @(posedge clk);

    check("a_pending_resp", ea_name.size(), 32'h0);
    check("a_pending_writes", wq_addr.size(), 32'h0);
    check("b_pending_resp", eb_data.size(), 32'h0);
    check("b_pending_addr", bq_addr.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
